dmi_arbiter: RTL

Parametrised debug-module-interface (DMI) arbiter between NUM_CH debug transport channels and a single debug module. Transports include the JTAG driver and a planned UART debug bridge. The block grants one request at a time round-robin, forwards it to the DM with valid/ready handshakes, and routes the response back to the originating channel. A cycle timeout synthesises a failed response if the DM never answers.

---
 rtl/dmi_pkg.sv | 24 ++
 rtl/dmi_arbiter_rr.sv | 27 ++
 rtl/dmi_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dmi_pkg.sv
// dmi_pkg: DMI op/status codes, arbiter FSM encoding and width helper
// shared by the DMI arbiter and its round-robin sub-block.
package dmi_pkg;

   localparam logic [1:0] DMI_OP_NOP  = 2'd0;
   localparam logic [1:0] DMI_OP_READ = 2'd1;
   localparam logic [1:0] DMI_OP_WRITE = 2'd2;

   localparam logic [1:0] DMI_RSP_SUCCESS = 2'd0;
   localparam logic [1:0] DMI_RSP_FAILED  = 2'd2;
   localparam logic [1:0] DMI_RSP_BUSY    = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } dmi_state_e;

   function automatic int req_bits(input int a, input int d, input int o);
      return a + d + o;
   endfunction

endpackage

// File: rtl/dmi_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker, one-hot grant,
// searching from last_i+1 modulo N.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int LW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [LW-1:0] last_i,
   output logic [N-1:0]  gnt_o
);

   int c;

   // Walk farthest-first so the nearest requester overwrites the rest.
   always_comb begin
      gnt_o = '0;
      c     = 0;
      for (int i = N; i >= 1; i--) begin
         c = (int'(last_i) + i) % N;
         if (req_i[c]) begin
            gnt_o    = '0;
            gnt_o[c] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmi_arbiter.sv
// dmi_arbiter: round-robin DMI arbiter, one outstanding transaction,
// with a grant-to-response timeout that synthesises a FAILED response.
module dmi_arbiter
   import dmi_pkg::*;
#(
   parameter int DMI_ADDR_BITS  = 6,
   parameter int DMI_DATA_BITS  = 32,
   parameter int DMI_OP_BITS    = 2,
   parameter int NUM_CH         = 2,
   parameter int TIMEOUT_CYCLES = 255,
   localparam int REQ_BITS = req_bits(DMI_ADDR_BITS, DMI_DATA_BITS, DMI_OP_BITS),
   localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          ch_req_valid_i,
   output logic [NUM_CH-1:0]          ch_req_ready_o,
   input  logic [NUM_CH*REQ_BITS-1:0] ch_req_data_i,
   output logic [NUM_CH-1:0]          ch_resp_valid_o,
   input  logic [NUM_CH-1:0]          ch_resp_ready_i,
   output logic [REQ_BITS-1:0]        ch_resp_data_o,
   output logic                       dm_req_valid_o,
   input  logic                       dm_req_ready_i,
   output logic [REQ_BITS-1:0]        dm_req_data_o,
   input  logic                       dm_resp_valid_i,
   output logic                       dm_resp_ready_o,
   input  logic [REQ_BITS-1:0]        dm_resp_data_i,
   output logic                       busy_o,
   output logic [GW-1:0]              grant_o,
   output logic                       timeout_o,
   output logic                       stray_resp_o
);

   localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
   localparam int CW = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_EXP = CW'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

   dmi_state_e          state_q;
   logic [REQ_BITS-1:0] req_q, resp_q, tmo_resp, pick_data;
   logic [GW-1:0]       grant_q, last_q, pick_idx;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                timeout_q, stray_q, tmo_hit, any_req;
   logic [NUM_CH-1:0]   pick_oh;

   rr_arbiter #(
      .N  (NUM_CH),
      .LW (GW)
   ) u_rr (
      .req_i  (ch_req_valid_i),
      .last_i (last_q),
      .gnt_o  (pick_oh)
   );

   always_comb begin
      pick_idx = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (pick_oh[k]) pick_idx = GW'(k);
      end
   end

   assign any_req   = |ch_req_valid_i;
   assign pick_data = ch_req_data_i[pick_idx*REQ_BITS +: REQ_BITS];
   assign cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
   assign tmo_hit   = TMO_EN && (cnt_q >= CNT_EXP);
   assign tmo_resp  = {req_q[REQ_BITS-1 -: DMI_ADDR_BITS],
                       {DMI_DATA_BITS{1'b0}},
                       DMI_OP_BITS'(DMI_RSP_FAILED)};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         req_q     <= '0;
         resp_q    <= '0;
         grant_q   <= '0;
         last_q    <= GW'(NUM_CH - 1);
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         stray_q   <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         stray_q   <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               stray_q <= dm_resp_valid_i;
               if (any_req) begin
                  req_q   <= pick_data;
                  grant_q <= pick_idx;
                  last_q  <= pick_idx;
                  cnt_q   <= '0;
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cnt_q <= cnt_d;
               // Acceptance on the expiry cycle still counts.
               if (dm_req_ready_i) begin
                  state_q <= ST_WAIT;
               end else if (tmo_hit) begin
                  resp_q    <= tmo_resp;
                  timeout_q <= 1'b1;
                  state_q   <= ST_RESP;
               end
            end
            ST_WAIT: begin
               cnt_q <= cnt_d;
               if (dm_resp_valid_i) begin
                  resp_q  <= dm_resp_data_i;
                  state_q <= ST_RESP;
               end else if (tmo_hit) begin
                  resp_q    <= tmo_resp;
                  timeout_q <= 1'b1;
                  state_q   <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (ch_resp_ready_i[grant_q]) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      ch_resp_valid_o = '0;
      if (state_q == ST_RESP) ch_resp_valid_o[grant_q] = 1'b1;
   end

   assign ch_req_ready_o  = (state_q == ST_IDLE && !rst) ? pick_oh : '0;
   assign ch_resp_data_o  = resp_q;
   assign dm_req_valid_o  = (state_q == ST_ISSUE);
   assign dm_req_data_o   = req_q;
   assign dm_resp_ready_o = (state_q == ST_IDLE) || (state_q == ST_WAIT);
   assign busy_o          = (state_q != ST_IDLE);
   assign grant_o         = grant_q;
   assign timeout_o       = timeout_q;
   assign stray_resp_o    = stray_q;

endmodule
